fact_datapath: RTL and testbench

//  Datapath for the iterative factorial unit: down-counter, multiply/accumulate register,

---
 rtl/fact_datapath.sv | 107 ++++++++++
 tb/tb_fact_datapath.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fact_datapath.sv
`default_nettype none
// ============================================================================
// Module      : fact_datapath
// Description : Datapath for the iterative factorial unit. It contains a
//               loadable down-counter, a multiply/accumulate register with a
//               sticky overflow flag, the cnt > 1 comparator, and an output
//               buffer that publishes the result and overflow flag.
//               The control FSM drives {cld, cen, s1, ren, ben}, and the
//               datapath returns 'greater' to it.
// Ports       : clk     - clock, rising edge
//               rst     - asynchronous active-high reset
//               n       - operand, sampled on counter load (cld & cen)
//               cld     - counter load select
//               cen     - counter enable
//               s1      - acc mux select: 0 = constant 1, 1 = acc*cnt
//               ren     - accumulator enable
//               ben     - output buffer enable
//               greater - cnt > 1 (combinational from counter register)
//               result  - registered factorial result (truncated to RES_W)
//               ovf     - registered overflow flag of the published result
// Revision    : 1.0 - initial release
// ============================================================================
module fact_datapath #(
  parameter int DATA_W = 4,
  parameter int RES_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] n,
  input  logic              cld,
  input  logic              cen,
  input  logic              s1,
  input  logic              ren,
  input  logic              ben,
  output logic              greater,
  output logic [RES_W-1:0]  result,
  output logic              ovf
);

  localparam int FULL_W = RES_W + DATA_W;

  logic [DATA_W-1:0] r_cnt;
  logic [RES_W-1:0]  r_acc;
  logic              r_ovf_acc;
  logic [RES_W-1:0]  r_result;
  logic              r_ovf;

  logic [FULL_W-1:0] w_full;
  logic [RES_W-1:0]  w_prod;
  logic              w_hi_nz;

  // Both operands are zero-extended to the full width so the product keeps
  // every bit; the upper DATA_W bits reveal whether truncation lost data.
  assign w_full  = {{DATA_W{1'b0}}, r_acc} * {{RES_W{1'b0}}, r_cnt};
  assign w_prod  = w_full[RES_W-1:0];
  assign w_hi_nz = |w_full[FULL_W-1:RES_W];

  assign greater = (r_cnt > DATA_W'(1));
  assign result  = r_result;
  assign ovf     = r_ovf;

  // Down-counter. Decrement wraps modulo 2^DATA_W by design.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (cen) begin
      if (cld) begin
        r_cnt <= n;
      end else begin
        r_cnt <= r_cnt - DATA_W'(1);
      end
    end
  end

  // Accumulator and sticky overflow. The product uses the counter value from
  // before this edge, because the counter decrements on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc     <= '0;
      r_ovf_acc <= 1'b0;
    end else if (ren) begin
      if (s1) begin
        r_acc <= w_prod;
        if (w_hi_nz) begin
          r_ovf_acc <= 1'b1;
        end
      end else begin
        // Loading the constant 1 starts a new computation, so overflow clears.
        r_acc     <= RES_W'(1);
        r_ovf_acc <= 1'b0;
      end
    end
  end

  // Output buffer keeps the previous result stable while the next run proceeds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= '0;
      r_ovf    <= 1'b0;
    end else if (ben) begin
      r_result <= r_acc;
      r_ovf    <= r_ovf_acc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fact_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_fact_datapath
// Description : Self-checking bench for fact_datapath. Stimulus drives the
//               control sequence and pushes expected {result, ovf} values into
//               a queue, and a monitor pops and compares one edge after ben.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fact_datapath;

  localparam int DATA_W = 4;
  localparam int RES_W  = 32;

  // Control words {cld, cen, s1, ren, ben}
  localparam logic [4:0] C_LOAD = 5'b11010;
  localparam logic [4:0] C_WAIT = 5'b00000;
  localparam logic [4:0] C_DEC  = 5'b01110;
  localparam logic [4:0] C_DONE = 5'b00001;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] n;
  logic              cld, cen, s1, ren, ben;
  logic              greater;
  logic [RES_W-1:0]  result;
  logic              ovf;

  int total;
  int bad;

  logic [RES_W:0] exp_q[$];
  logic           ben_q;
  logic [RES_W-1:0] last_res;

  fact_datapath #(.DATA_W(DATA_W), .RES_W(RES_W)) dut (
    .clk(clk), .rst(rst), .n(n), .cld(cld), .cen(cen), .s1(s1),
    .ren(ren), .ben(ben), .greater(greater), .result(result), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic set_ctrl(input logic [4:0] c);
    {cld, cen, s1, ren, ben} = c;
  endtask

  // Apply a control word for one cycle; returns 1 ns after the rising edge.
  task automatic step(input logic [4:0] c);
    set_ctrl(c);
    @(posedge clk);
    #1;
  endtask

  // Monitor: the buffer captures on a ben edge, so compare on the next negedge.
  always @(posedge clk or posedge rst) begin
    if (rst) ben_q <= 1'b0;
    else     ben_q <= ben;
  end

  always @(negedge clk) begin
    if (ben_q) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard: got result=%0d with no expected entry", result);
      end else begin
        logic [RES_W:0] e;
        e = exp_q.pop_front();
        chk("result", 64'(result), 64'(e[RES_W:1]));
        chk("ovf",    64'(ovf),    64'(e[0]));
      end
    end
  end

  // One full factorial run following the FSM's control sequence.
  task automatic run(input logic [DATA_W-1:0] nv, input int exp_gcnt,
                     input logic [RES_W-1:0] exp_res, input logic exp_ovf);
    int  gcnt;
    logic g;
    gcnt = 0;
    n = nv;
    step(C_LOAD);
    for (int i = 0; i < 20; i++) begin
      set_ctrl(C_WAIT);
      g = greater;
      step(C_WAIT);
      if (!g) break;
      gcnt++;
      step(C_DEC);
    end
    chk("greater_cycles", 64'(gcnt), 64'(exp_gcnt));
    // Previous result must still be held just before Done.
    chk("result_hold", 64'(result), 64'(last_res));
    exp_q.push_back({exp_res, exp_ovf});
    step(C_DONE);
    step(C_WAIT);
    last_res = exp_res;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    last_res = '0;
    n = '0;
    set_ctrl(5'b00000);
    rst = 1'b1;
    #12;
    chk("rst_greater", 64'(greater), 64'd0);
    chk("rst_result",  64'(result),  64'd0);
    chk("rst_ovf",     64'(ovf),     64'd0);
    @(negedge clk);
    rst = 1'b0;

    run(4'd5,  4,  32'd120, 1'b0);
    run(4'd0,  0,  32'd1,   1'b0);
    run(4'd1,  0,  32'd1,   1'b0);
    run(4'd12, 11, 32'd479001600, 1'b0);
    run(4'd13, 12, 32'd1932053504, 1'b1);
    run(4'd3,  2,  32'd6,   1'b0);

    // Asynchronous reset during the 3rd Dec cycle of n=7.
    n = 4'd7;
    step(C_LOAD);
    step(C_WAIT);
    step(C_DEC);
    step(C_WAIT);
    step(C_DEC);
    step(C_WAIT);
    set_ctrl(C_DEC);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_greater", 64'(greater),       64'd0);
    chk("arst_result",  64'(result),        64'd0);
    chk("arst_ovf",     64'(ovf),           64'd0);
    chk("arst_cnt",     64'(dut.r_cnt),     64'd0);
    chk("arst_acc",     64'(dut.r_acc),     64'd0);
    set_ctrl(C_WAIT);
    @(negedge clk);
    rst = 1'b0;
    last_res = '0;
    run(4'd4, 3, 32'd24, 1'b0);

    // Counter wrap from 0 and cld-alone hold.
    n = 4'd0;
    step(C_LOAD);
    chk("wrap_pre_greater", 64'(greater), 64'd0);
    step(5'b01000);
    chk("wrap_cnt",     64'(dut.r_cnt), 64'd15);
    chk("wrap_greater", 64'(greater),   64'd1);
    n = 4'd2;
    step(5'b10000);
    chk("cld_only_cnt",     64'(dut.r_cnt), 64'd15);
    chk("cld_only_greater", 64'(greater),   64'd1);

    step(C_WAIT);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
